// File: rtl/seq_detect_pkg.sv
// Shared defaults and compare helper for the serial pattern detectors.
// The defaults reproduce the fixed 4-bit detector this block replaces.
package seq_detect_pkg;

   localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;
   localparam int         DEFAULT_LEN     = 4;
   localparam logic       DEFAULT_OVERLAP = 1'b0;
   localparam int         PAT_MAX         = 32;

   // True when the low len bits of hist and pat agree; len >= 32 compares all bits.
   function automatic logic masked_match(input logic [PAT_MAX-1:0] hist,
                                         input logic [PAT_MAX-1:0] pat,
                                         input logic [5:0]         len);
      logic [PAT_MAX-1:0] mask;
      mask = (len >= 6'd32) ? '1 : ((32'd1 << len) - 32'd1);
      return ((hist ^ pat) & mask) == '0;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a clear that overrides a same-cycle increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (reset || clr)
         cnt <= '0;
      else if (inc && (cnt != '1))
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector with overlap select and a
// saturating detection count.
module seq_detect_prog
   import seq_detect_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 16,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               inp_valid,
   input  logic               inp_bit,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               count_clr,
   output logic               seq_seen,
   output logic [CNT_W-1:0]   match_cnt
);

   // Default length clamped so tiny MAX_LEN builds still elaborate sanely.
   localparam int DEF_LEN = (DEFAULT_LEN > MAX_LEN) ? MAX_LEN : DEFAULT_LEN;

   logic [MAX_LEN-1:0] hist;
   logic [LEN_W-1:0]   fill;
   logic [MAX_LEN-1:0] act_pat;
   logic [LEN_W-1:0]   act_len;
   logic               act_ovl;

   logic [MAX_LEN-1:0] hist_next;
   logic [LEN_W-1:0]   fill_inc;
   logic [LEN_W-1:0]   eff_len;
   logic               match;

   always_comb begin
      hist_next = {hist[MAX_LEN-2:0], inp_bit};
      fill_inc  = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
      eff_len   = (act_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : act_len;
      match     = 1'b0;
      // A load in the same cycle discards the bit, so it can never match.
      if (inp_valid && !cfg_load && (eff_len != '0) && (fill_inc >= eff_len))
         match = masked_match(PAT_MAX'(hist_next), PAT_MAX'(act_pat), 6'(eff_len));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hist     <= '0;
         fill     <= '0;
         act_pat  <= MAX_LEN'(DEFAULT_PATTERN);
         act_len  <= LEN_W'(DEF_LEN);
         act_ovl  <= DEFAULT_OVERLAP;
         seq_seen <= 1'b0;
      end else if (cfg_load) begin
         hist     <= '0;
         fill     <= '0;
         act_pat  <= cfg_pattern;
         act_len  <= cfg_len;
         act_ovl  <= cfg_overlap;
         seq_seen <= 1'b0;
      end else begin
         seq_seen <= match;
         if (inp_valid) begin
            hist <= hist_next;
            // Non-overlap: consumed bits must not feed the next match.
            fill <= (match && !act_ovl) ? '0 : fill_inc;
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (match),
      .clr   (count_clr),
      .cnt   (match_cnt)
   );

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog: a reference model queues the expected
// seq_seen/match_cnt per driven cycle, each test pops and compares them.
module tb_seq_detect_prog;

   logic       clk = 1'b0;
   logic       reset, inp_valid, inp_bit, cfg_load, cfg_overlap, count_clr;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       seq_seen;
   logic [3:0] match_cnt;

   int errors = 0;
   int checks = 0;

   bit         exp_seen_q[$];
   logic [3:0] exp_cnt_q[$];

   logic [7:0] m_pat;
   int         m_len;
   bit         m_ovl;
   bit         m_bits[$];
   int         m_cnt;

   always #5 clk = ~clk;

   seq_detect_prog #(.MAX_LEN(8), .CNT_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .inp_valid   (inp_valid),
      .inp_bit     (inp_bit),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .count_clr   (count_clr),
      .seq_seen    (seq_seen),
      .match_cnt   (match_cnt)
   );

   // Drive one cycle; non-reset cycles push the model's expectation.
   task automatic step(input bit rst, input bit v, input bit b, input bit ld,
                       input bit clr, input logic [7:0] pat,
                       input logic [3:0] len, input bit ovl);
      bit e;
      int l;
      e = 1'b0;
      if (rst) begin
         m_pat = 8'b0000_1011; m_len = 4; m_ovl = 1'b0; m_cnt = 0;
         m_bits.delete();
      end else begin
         if (ld) begin
            m_pat = pat; m_len = int'(len); m_ovl = ovl;
            m_bits.delete();
         end else if (v) begin
            m_bits.push_back(b);
            l = (m_len > 8) ? 8 : m_len;
            if (l > 0 && m_bits.size() >= l) begin
               e = 1'b1;
               for (int i = 0; i < l; i++)
                  if (m_bits[m_bits.size()-1-i] != m_pat[i]) e = 1'b0;
            end
            if (e && !m_ovl) m_bits.delete();
         end
         if (clr) m_cnt = 0;
         else if (e && m_cnt < 15) m_cnt++;
         exp_seen_q.push_back(e);
         exp_cnt_q.push_back(4'(m_cnt));
      end
      reset = rst; inp_valid = v; inp_bit = b; cfg_load = ld; count_clr = clr;
      cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 4'd1, 1'b1);
      checks++;
      if (seq_seen !== 1'b0) begin
         errors++; $display("FAIL reset_seen: got %b want 0", seq_seen);
      end
      checks++;
      if (match_cnt !== 4'd0) begin
         errors++; $display("FAIL reset_cnt: got %0d want 0", match_cnt);
      end
   endtask

   task automatic test_default;
      logic [6:0] s = 7'b1011011;
      logic [15:0] pm = '0;
      bit es; logic [3:0] ec;
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b1, s[6-i], 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
         es = exp_seen_q.pop_front(); ec = exp_cnt_q.pop_front();
         pm[i] = seq_seen;
         checks++;
         if (seq_seen !== es || match_cnt !== ec) begin
            errors++;
            $display("FAIL default bit%0d: seen=%b cnt=%0d want %b/%0d", i, seq_seen, match_cnt, es, ec);
         end
      end
      checks++;
      if (pm !== 16'h0008 || match_cnt !== 4'd1) begin
         errors++; $display("FAIL default_pulses: mask=%h cnt=%0d want 0008/1", pm, match_cnt);
      end
   endtask

   task automatic test_overlap;
      logic [6:0] s = 7'b1011011;
      logic [15:0] pm = '0;
      bit es; logic [3:0] ec;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'b0000_1011, 4'd4, 1'b1);
      es = exp_seen_q.pop_front(); ec = exp_cnt_q.pop_front();
      checks++;
      if (seq_seen !== es || match_cnt !== ec) begin
         errors++; $display("FAIL overlap_load: seen=%b cnt=%0d want %b/%0d", seq_seen, match_cnt, es, ec);
      end
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b1, s[6-i], 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
         es = exp_seen_q.pop_front(); ec = exp_cnt_q.pop_front();
         pm[i] = seq_seen;
         checks++;
         if (seq_seen !== es || match_cnt !== ec) begin
            errors++;
            $display("FAIL overlap bit%0d: seen=%b cnt=%0d want %b/%0d", i, seq_seen, match_cnt, es, ec);
         end
      end
      checks++;
      if (pm !== 16'h0048 || match_cnt !== 4'd2) begin
         errors++; $display("FAIL overlap_pulses: mask=%h cnt=%0d want 0048/2", pm, match_cnt);
      end
   endtask

   task automatic test_no_loss;
      logic [4:0] s = 5'b11011;
      logic [15:0] pm = '0;
      bit es; logic [3:0] ec;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, s[4-i], 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
         es = exp_seen_q.pop_front(); ec = exp_cnt_q.pop_front();
         pm[i] = seq_seen;
         checks++;
         if (seq_seen !== es || match_cnt !== ec) begin
            errors++;
            $display("FAIL no_loss bit%0d: seen=%b cnt=%0d want %b/%0d", i, seq_seen, match_cnt, es, ec);
         end
      end
      checks++;
      if (pm !== 16'h0010 || match_cnt !== 4'd1) begin
         errors++; $display("FAIL no_loss_pulses: mask=%h cnt=%0d want 0010/1", pm, match_cnt);
      end
   endtask

   task automatic test_gaps;
      logic [7:0] s = 8'b1111_0000;
      logic [15:0] pm = '0;
      bit es; logic [3:0] ec;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'b1111_0000, 4'd8, 1'b0);
      void'(exp_seen_q.pop_front()); void'(exp_cnt_q.pop_front());
      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 0)
            step(1'b0, 1'b1, s[7-i/2], 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
         else
            step(1'b0, 1'b0, 1'($urandom_range(1)), 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
         es = exp_seen_q.pop_front(); ec = exp_cnt_q.pop_front();
         pm[i] = seq_seen;
         checks++;
         if (seq_seen !== es || match_cnt !== ec) begin
            errors++;
            $display("FAIL gaps step%0d: seen=%b cnt=%0d want %b/%0d", i, seq_seen, match_cnt, es, ec);
         end
      end
      checks++;
      if (pm !== 16'h4000 || match_cnt !== 4'd1) begin
         errors++; $display("FAIL gaps_pulses: mask=%h cnt=%0d want 4000/1", pm, match_cnt);
      end
   endtask

   task automatic test_saturation;
      bit es; logic [3:0] ec;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 4'd1, 1'b1);
      void'(exp_seen_q.pop_front()); void'(exp_cnt_q.pop_front());
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
         es = exp_seen_q.pop_front(); ec = exp_cnt_q.pop_front();
         checks++;
         if (seq_seen !== es || match_cnt !== ec) begin
            errors++;
            $display("FAIL sat bit%0d: seen=%b cnt=%0d want %b/%0d", i, seq_seen, match_cnt, es, ec);
         end
      end
      checks++;
      if (match_cnt !== 4'd15) begin
         errors++; $display("FAIL sat_hold: cnt=%0d want 15", match_cnt);
      end
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0);
      void'(exp_seen_q.pop_front()); void'(exp_cnt_q.pop_front());
      checks++;
      if (seq_seen !== 1'b1 || match_cnt !== 4'd0) begin
         errors++; $display("FAIL clr_priority: seen=%b cnt=%0d want 1/0", seq_seen, match_cnt);
      end
   endtask

   task automatic test_reset_mid;
      logic [3:0] s = 4'b1011;
      int pulses = 0;
      bit es; logic [3:0] ec;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
         step(1'b0, 1'b1, s[3-i], 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
         es = exp_seen_q.pop_front(); ec = exp_cnt_q.pop_front();
         pulses += int'(seq_seen);
         checks++;
         if (seq_seen !== es || match_cnt !== ec) begin
            errors++;
            $display("FAIL reset_mid bit%0d: seen=%b cnt=%0d want %b/%0d", i, seq_seen, match_cnt, es, ec);
         end
      end
      checks++;
      if (pulses != 0) begin
         errors++; $display("FAIL reset_mid_pulses: got %0d want 0", pulses);
      end
   endtask

   task automatic test_len0;
      int pulses = 0;
      bit es; logic [3:0] ec;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'($urandom), 4'd0, 1'b1);
      void'(exp_seen_q.pop_front()); void'(exp_cnt_q.pop_front());
      for (int i = 0; i < 32; i++) begin
         step(1'b0, 1'b1, 1'($urandom_range(1)), 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
         es = exp_seen_q.pop_front(); ec = exp_cnt_q.pop_front();
         pulses += int'(seq_seen);
         checks++;
         if (seq_seen !== es || match_cnt !== ec) begin
            errors++;
            $display("FAIL len0 bit%0d: seen=%b cnt=%0d want %b/%0d", i, seq_seen, match_cnt, es, ec);
         end
      end
      checks++;
      if (pulses != 0 || match_cnt !== 4'd0) begin
         errors++; $display("FAIL len0_pulses: pulses=%0d cnt=%0d want 0/0", pulses, match_cnt);
      end
   endtask

   task automatic test_load_collision;
      logic [2:0]  pre = 3'b101;
      logic [6:0]  s   = 7'b0111011;
      logic [15:0] pm  = '0;
      bit es; logic [3:0] ec;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, pre[2-i], 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
         void'(exp_seen_q.pop_front()); void'(exp_cnt_q.pop_front());
      end
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'b0000_1011, 4'd4, 1'b0);
      es = exp_seen_q.pop_front(); ec = exp_cnt_q.pop_front();
      checks++;
      if (seq_seen !== es || match_cnt !== ec) begin
         errors++; $display("FAIL collide_load: seen=%b cnt=%0d want %b/%0d", seq_seen, match_cnt, es, ec);
      end
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b1, s[6-i], 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
         es = exp_seen_q.pop_front(); ec = exp_cnt_q.pop_front();
         pm[i] = seq_seen;
         checks++;
         if (seq_seen !== es || match_cnt !== ec) begin
            errors++;
            $display("FAIL collide bit%0d: seen=%b cnt=%0d want %b/%0d", i, seq_seen, match_cnt, es, ec);
         end
      end
      checks++;
      if (pm !== 16'h0040) begin
         errors++; $display("FAIL collide_pulses: mask=%h want 0040", pm);
      end
   endtask

   task automatic test_random;
      bit es; logic [3:0] ec;
      for (int r = 0; r < 4; r++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'($urandom),
              (r == 3) ? 4'd12 : 4'($urandom_range(5, 1)), 1'(r % 2));
         void'(exp_seen_q.pop_front()); void'(exp_cnt_q.pop_front());
         for (int i = 0; i < 150; i++) begin
            step(1'b0, 1'($urandom_range(9) != 0), 1'($urandom_range(1)),
                 1'b0, 1'($urandom_range(40) == 0), 8'h00, 4'd0, 1'b0);
            es = exp_seen_q.pop_front(); ec = exp_cnt_q.pop_front();
            checks++;
            if (seq_seen !== es || match_cnt !== ec) begin
               errors++;
               $display("FAIL random r%0d c%0d: seen=%b cnt=%0d want %b/%0d", r, i, seq_seen, match_cnt, es, ec);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1; inp_valid = 1'b0; inp_bit = 1'b0; cfg_load = 1'b0;
      count_clr = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
      @(negedge clk);
      test_reset;
      test_default;
      test_overlap;
      test_no_loss;
      test_gaps;
      test_saturation;
      test_reset_mid;
      test_len0;
      test_load_collision;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
- Programmable serial bit-pattern detector, and the successor to the fixed 4-bit detector.
- Pattern length up to MAX_LEN, pattern value runtime-loadable, overlapping or non-overlapping detection selectable, input qualified by a valid strobe.
- Keeps a saturating count of detections for status readback.
- Sits on the serial input path ahead of framing/control logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- CNT_W, 16, width of the detection counter.
- LEN_W, $clog2(MAX_LEN+1), width of the length field (derived; do not override).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- inp_valid  in  1  inp_bit is sampled on this edge
- inp_bit  in  1  serial data bit
- cfg_load  in  1  one-cycle strobe: latch cfg_pattern/cfg_len/cfg_overlap
- cfg_pattern  in  MAX_LEN  pattern; bit cfg_len-1 = oldest bit, bit 0 = newest bit
- cfg_len  in  LEN_W  pattern length
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- count_clr  in  1  one-cycle strobe: clear match_cnt
- seq_seen  out  1  registered one-cycle detection pulse
- match_cnt  out  CNT_W  saturating detection count

Behaviour:
- Reset values:
  - seq_seen=0, match_cnt=0.
  - history and fill counter cleared.
  - Active config = pattern 4'b1011 (zero-extended), len 4, overlap 0. This is drop-in equivalent to the predecessor.
- History register hist[MAX_LEN-1:0]:
  - On an edge with inp_valid=1: hist <= {hist[MAX_LEN-2:0], inp_bit}.
  - fill <= min(fill+1, MAX_LEN).
- Effective length L:
  - L = cfg_len, clamped to MAX_LEN if larger.
  - L=0 disables detection: no seq_seen, no counting.
- Match condition, evaluated on the edge with inp_valid=1, using the post-shift history: fill_next >= L and low L bits of the new hist == low L bits of the pattern.
- Match response:
  - seq_seen=1 in the cycle following that edge (latency 1 from the sampled bit), for exactly one cycle.
  - seq_seen=0 on every cycle without a match, including cycles with inp_valid=0.
- Non-overlap mode: on a match, fill <= 0. The matching bits cannot contribute to the next match.
- Overlap mode: fill is unchanged on a match. Trailing bits are reused.
- Bits between matches are never lost; there is no FSM restart bug. For example, "11011" with pattern 1011 still matches.
- cfg_load:
  - Latches the new config and clears hist and fill.
  - seq_seen=0 next cycle. match_cnt is unchanged.
  - If inp_valid is also high, cfg_load wins and the bit is discarded.
- match_cnt:
  - Increments on each match and saturates at all-ones; no wrap.
  - If count_clr and a match occur together, clear wins: result is 0.
- Reset mid-stream: all state returns to reset values on that edge, regardless of cfg_load or inp_valid. Config reverts to the default.
- inp_valid=0 cycles freeze hist and fill; the stream is gap-tolerant.
- Unused pattern bits above L are ignored.

Decomposition:
- Shared package seq_detect_pkg holds:
  - DEFAULT_PATTERN = 4'b1011, DEFAULT_LEN = 4, DEFAULT_OVERLAP = 0.
  - A function for the length-masked compare, reused by future multi-channel variants.
- One natural sub-module, sat_counter (parameter W; inputs inc, clr; clear priority), instantiated for match_cnt.
- History, fill and compare logic stay in the top level.

Test Plan:
- Default after reset, stream 1,0,1,1,0,1,1 with inp_valid=1 every cycle:
  - Non-overlap gives exactly one pulse, the cycle after bit 4; match_cnt=1.
- Same stream after cfg_load with pattern 1011, len 4, overlap 1:
  - Pulses after bit 4 and bit 7; match_cnt=2.
- Stream 1,1,0,1,1 in default mode:
  - One pulse after bit 5. Checks no loss on a repeated leading 1.
- Pattern 8'b11110000, len 8, with inp_valid gaps inserted between bits:
  - One pulse the cycle after the 8th valid bit; none during the gaps.
- Saturation and clear priority, CNT_W=4, overlap, pattern 1 len 1, 20 ones:
  - match_cnt stops at 15.
  - count_clr on the same cycle as a match gives match_cnt=0.
- Edge cases:
  - Reset asserted after bits 1,0,1, then 1 → no pulse.
  - cfg_len=0 → no pulses over 32 random bits.
  - cfg_load on the same cycle as inp_valid → that bit is ignored.
